// File: rtl/rv_pkg.sv
// Shared types and constants for the RISC-V integer register file.
package rv_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [XLEN-1:0]       word_t;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/rv_regfile_rdport.sv
// One combinational read port: x0 masking plus optional write-before-read forwarding.
// Both read ports instantiate this, so the two paths are identical by construction.
module rv_regfile_rdport import rv_pkg::*; #(
    parameter int unsigned DW     = XLEN,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned AW     = $clog2(NREGS),
    parameter bit          BYPASS = 1'b1
) (
    input  logic [AW-1:0] raddr,
    input  logic [DW-1:0] regs [NREGS],
    input  logic          byp_en,
    input  logic [AW-1:0] byp_addr,
    input  logic [DW-1:0] byp_data,
    output logic [DW-1:0] rdata
);

    // x0 reads as zero; otherwise forward in-flight write data or read storage
    always_comb begin
        rdata = '0;
        if (raddr != AW'(REG_ZERO)) begin
            if (BYPASS && byp_en && (byp_addr == raddr)) begin
                rdata = byp_data;
            end else begin
                rdata = regs[raddr];
            end
        end
    end

endmodule

// File: rtl/rv_regfile.sv
// 32 x XLEN RISC-V integer register file: two combinational read ports,
// one synchronous write port, x0 hardwired to zero.
module rv_regfile import rv_pkg::*; #(
    parameter int unsigned XLEN   = rv_pkg::XLEN,
    parameter int unsigned NREGS  = 32,
    parameter bit          BYPASS = 1'b1,
    localparam int unsigned AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wenable,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2
);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_en;
    logic            byp_en;

    // Writes to x0 are dropped here, so regs[0] only ever holds its reset value
    assign wr_en  = wenable && (rd != AW'(REG_ZERO));
    // Reset wins over a simultaneous write, so the write must not be forwarded either
    assign byp_en = wr_en && !rst;

    // Storage update: reset clears everything, otherwise a single write per edge
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[rd] <= wdata;
        end
    end

    rv_regfile_rdport #(
        .DW     (XLEN),
        .NREGS  (NREGS),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_rdport1 (
        .raddr    (rs1),
        .regs     (regs),
        .byp_en   (byp_en),
        .byp_addr (rd),
        .byp_data (wdata),
        .rdata    (rd1)
    );

    rv_regfile_rdport #(
        .DW     (XLEN),
        .NREGS  (NREGS),
        .AW     (AW),
        .BYPASS (BYPASS)
    ) u_rdport2 (
        .raddr    (rs2),
        .regs     (regs),
        .byp_en   (byp_en),
        .byp_addr (rd),
        .byp_data (wdata),
        .rdata    (rd2)
    );

endmodule

// File: tb/tb_rv_regfile.sv
// Scoreboard bench for rv_regfile: one BYPASS=1 and one BYPASS=0 instance share stimulus.
module tb_rv_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        wenable;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] wdata;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          sel;   // 0:rd1 bypass 1:rd2 bypass 2:rd1 no-bypass 3:rd2 no-bypass
        logic [31:0] val;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    rv_regfile #(.XLEN(32), .NREGS(32), .BYPASS(1'b1)) u_dut_byp (
        .clk (clk), .rst (rst), .wenable (wenable), .rs1 (rs1), .rs2 (rs2),
        .rd (rd), .wdata (wdata), .rd1 (rd1_b), .rd2 (rd2_b)
    );

    rv_regfile #(.XLEN(32), .NREGS(32), .BYPASS(1'b0)) u_dut_nob (
        .clk (clk), .rst (rst), .wenable (wenable), .rs1 (rs1), .rs2 (rs2),
        .rd (rd), .wdata (wdata), .rd1 (rd1_n), .rd2 (rd2_n)
    );

    task automatic expect_val(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        q.push_back(e);
    endtask

    // Same expectation on both instances (bypass does not matter for this read)
    task automatic expect_both(input string name, input int port, input logic [31:0] val);
        expect_val(name, port, val);
        expect_val(name, port + 2, val);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: read ports are always presented, so drain pending expectations mid-cycle
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.sel)
                0:       act = rd1_b;
                1:       act = rd2_b;
                2:       act = rd1_n;
                default: act = rd2_n;
            endcase
            checks++;
            if (act !== e.val) begin
                errors++;
                $display("FAIL %s sel=%0d got=%h want=%h", e.name, e.sel, act, e.val);
            end
        end
    end

    initial begin
        rst     = 1'b1;
        wenable = 1'b0;
        rs1     = 5'd5;
        rs2     = 5'd31;
        rd      = 5'd0;
        wdata   = 32'h0;

        // Reset for one edge, then every address reads zero
        next_cycle();
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            rs1 = 5'(a);
            rs2 = 5'(31 - a);
            expect_both("reset_rd1", 0, 32'h0);
            expect_both("reset_rd2", 1, 32'h0);
            next_cycle();
        end

        // Basic write of x5; bypass visible before the edge only on the BYPASS=1 copy
        wenable = 1'b1; rd = 5'd5; wdata = 32'hAAAA5555; rs1 = 5'd5; rs2 = 5'd0;
        expect_val("wr5_byp", 0, 32'hAAAA5555);
        expect_val("wr5_nobyp", 2, 32'h0);
        expect_both("wr5_rs2_x0", 1, 32'h0);
        next_cycle();
        wenable = 1'b0; rs1 = 5'd5; rs2 = 5'd5;
        expect_both("rd5_p1", 0, 32'hAAAA5555);
        expect_both("rd5_p2", 1, 32'hAAAA5555);
        next_cycle();
        rs1 = 5'd0; rs2 = 5'd0;
        expect_both("rd0_p1", 0, 32'h0);
        expect_both("rd0_p2", 1, 32'h0);

        // x0 immutability, including no forwarding during the write cycle
        next_cycle();
        wenable = 1'b1; rd = 5'd0; wdata = 32'hFFFFFFFF; rs1 = 5'd0; rs2 = 5'd5;
        expect_both("x0_during_wr", 0, 32'h0);
        expect_both("x5_during_x0wr", 1, 32'hAAAA5555);
        next_cycle();
        wenable = 1'b0;
        expect_both("x0_after_wr", 0, 32'h0);

        // Back-to-back writes to x10 and x11
        next_cycle();
        wenable = 1'b1; rd = 5'd10; wdata = 32'h11112222; rs1 = 5'd1; rs2 = 5'd1;
        next_cycle();
        rd = 5'd11; wdata = 32'h33334444; rs1 = 5'd10;
        expect_both("x10_next_cycle", 0, 32'h11112222);
        next_cycle();
        wenable = 1'b0; rs1 = 5'd10; rs2 = 5'd11;
        expect_both("b2b_x10", 0, 32'h11112222);
        expect_both("b2b_x11", 1, 32'h33334444);

        // Bypass versus stored value for x7
        next_cycle();
        wenable = 1'b1; rd = 5'd7; wdata = 32'h01010101; rs1 = 5'd0; rs2 = 5'd0;
        next_cycle();
        wdata = 32'hDEADBEEF; rs1 = 5'd7; rs2 = 5'd7;
        expect_val("byp_x7_p1", 0, 32'hDEADBEEF);
        expect_val("byp_x7_p2", 1, 32'hDEADBEEF);
        expect_val("nobyp_x7_p1", 2, 32'h01010101);
        expect_val("nobyp_x7_p2", 3, 32'h01010101);
        next_cycle();
        wenable = 1'b0; wdata = 32'h55555555;
        expect_both("x7_hold_p1", 0, 32'hDEADBEEF);
        expect_both("x7_hold_p2", 1, 32'hDEADBEEF);
        next_cycle();
        expect_both("x7_unchanged", 0, 32'hDEADBEEF);

        // Reset beats a simultaneous write; no forwarding while rst is high
        next_cycle();
        wenable = 1'b1; rd = 5'd3; wdata = 32'h12345678; rs1 = 5'd0;
        next_cycle();
        wenable = 1'b0; rs1 = 5'd3; rs2 = 5'd5;
        expect_both("x3_stored", 0, 32'h12345678);
        next_cycle();
        rst = 1'b1; wenable = 1'b1; rd = 5'd3; wdata = 32'hCAFEF00D;
        expect_both("rst_no_byp_x3", 0, 32'h12345678);
        expect_both("rst_cycle_x5", 1, 32'hAAAA5555);
        next_cycle();
        rst = 1'b0; wenable = 1'b0;
        expect_both("rst_prio_x3", 0, 32'h0);
        expect_both("rst_clr_x5", 1, 32'h0);

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
